fifo_uart_drain: RTL and testbench

Read-side consumer for the I2C capture FIFO. Pops one DATA_WIDTH-bit word at a time from the synchronous FIFO and serialises it over a UART 8N1 link to the host, byte by byte. Sits between the capture FIFO's read port and the board's UART TX pin, completing the monitor's logging path.

---
 rtl/uart_drain_pkg.sv | 31 +++
 rtl/uart_tx_byte.sv | 114 +++++++++++
 rtl/fifo_uart_drain.sv | 123 ++++++++++++
 tb/tb_fifo_uart_drain.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_drain_pkg.sv
// Shared types and constants for the FIFO-to-UART drain path.
// Optional feature macro: UART_DRAIN_PARITY_EN (adds an even-parity bit, 8E1).
package uart_drain_pkg;

  // Full state set of the drain path. The byte engine runs START..STOP;
  // the top-level controller covers IDLE, FETCH and LOAD.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

  // Top-level controller states; DR_SEND covers every state owned by the byte engine.
  typedef enum logic [1:0] {
    DR_IDLE  = 2'd0,
    DR_FETCH = 2'd1,
    DR_LOAD  = 2'd2,
    DR_SEND  = 2'd3
  } drain_e;

  localparam logic TX_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART transmitter: start bit, 8 data bits LSB first,
// optional even parity bit (UART_DRAIN_PARITY_EN), stop bit.
// o_byte_done is high during the last cycle of the stop bit; if i_start is
// high in that same cycle the next byte begins with no idle gap.
// i_start is honoured only in IDLE or in that final stop cycle.
module uart_tx_byte
  import uart_drain_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_byte_done,
  output logic [2:0] o_state
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          w_bit_end;
  logic          w_last_bit;
  logic          w_load;
`ifdef UART_DRAIN_PARITY_EN
  logic          r_parity;
`endif

  assign w_bit_end  = (r_cnt == CNT_LAST);
  assign w_last_bit = (r_bit_idx == LAST_BIT);
  assign w_load     = i_start && ((r_state == IDLE) || (r_state == STOP && w_bit_end));
  assign o_state    = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and the end-of-byte pulse.
  always_comb begin
    w_state_nxt = r_state;
    o_byte_done = 1'b0;
    case (r_state)
      IDLE:   if (w_load) w_state_nxt = START;
      START:  if (w_bit_end) w_state_nxt = DATA;
      DATA: begin
        if (w_bit_end && w_last_bit) begin
`ifdef UART_DRAIN_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
      PARITY: if (w_bit_end) w_state_nxt = STOP;
      STOP: begin
        if (w_bit_end) begin
          o_byte_done = 1'b1;
          w_state_nxt = w_load ? START : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level decoded from the current state; idle and reset drive mark (1).
  always_comb begin
    o_tx = TX_IDLE;
    case (r_state)
      START:  o_tx = START_BIT;
      DATA:   o_tx = r_shift[0];
`ifdef UART_DRAIN_PARITY_EN
      PARITY: o_tx = r_parity;
`endif
      STOP:   o_tx = STOP_BIT;
      default: o_tx = TX_IDLE;
    endcase
  end

  // Baud counter, bit index and data shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef UART_DRAIN_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE || w_bit_end) r_cnt <= '0;
      else                              r_cnt <= r_cnt + 1'b1;

      if (w_load) begin
        r_shift   <= i_data;
        r_bit_idx <= '0;
`ifdef UART_DRAIN_PARITY_EN
        r_parity  <= ^i_data;
`endif
      end else if (r_state == DATA && w_bit_end) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops words from a synchronous FIFO and sends them over UART,
// most-significant byte first. Build option UART_DRAIN_PARITY_EN selects 8E1 frames.
// dbg_state reports the combined drain state using uart_drain_pkg::state_e encoding.
module fifo_uart_drain
  import uart_drain_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic [15:0]           words_sent,
  output logic [2:0]            dbg_state
);

  localparam int BYTES = DATA_WIDTH / BITS_PER_BYTE;
  localparam int BW    = (BYTES > 2) ? $clog2(BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);

  drain_e                r_state;
  drain_e                w_state_nxt;
  logic                  r_rd_en;
  logic [DATA_WIDTH-1:0] r_word;
  logic [DATA_WIDTH-1:0] w_word_next;
  logic [BW-1:0]         r_byte_idx;
  logic [15:0]           r_words_sent;
  logic                  w_byte_done;
  logic                  w_last_byte;
  logic                  w_tx_start;
  logic [7:0]            w_tx_data;
  logic [2:0]            w_tx_state;

  assign w_last_byte = (r_byte_idx == LAST_BYTE);
  assign w_word_next = r_word << BITS_PER_BYTE;
  assign fifo_rd_en  = r_rd_en;
  assign busy        = (r_state != DR_IDLE);
  assign words_sent  = r_words_sent;

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DR_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Word sequencing. The first byte comes straight from the FIFO read data in
  // LOAD so the start bit follows one cycle later; later bytes come from the
  // shifted word register on the final stop cycle of the previous byte.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_start  = 1'b0;
    w_tx_data   = w_word_next[DATA_WIDTH-1 -: BITS_PER_BYTE];
    case (r_state)
      DR_IDLE:  if (enable && !fifo_empty) w_state_nxt = DR_FETCH;
      DR_FETCH: w_state_nxt = DR_LOAD;
      DR_LOAD: begin
        w_state_nxt = DR_SEND;
        w_tx_start  = 1'b1;
        w_tx_data   = fifo_rd_data[DATA_WIDTH-1 -: BITS_PER_BYTE];
      end
      DR_SEND: begin
        if (w_byte_done) begin
          if (w_last_byte) w_state_nxt = DR_IDLE;
          else             w_tx_start  = 1'b1;
        end
      end
      default: w_state_nxt = DR_IDLE;
    endcase
  end

  // Registered pop strobe, word/byte bookkeeping and the completed-word count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en      <= 1'b0;
      r_word       <= '0;
      r_byte_idx   <= '0;
      r_words_sent <= '0;
    end else begin
      r_rd_en <= (w_state_nxt == DR_FETCH);
      if (r_state == DR_LOAD) begin
        r_word     <= fifo_rd_data;
        r_byte_idx <= '0;
      end else if (r_state == DR_SEND && w_byte_done) begin
        if (w_last_byte) begin
          r_words_sent <= r_words_sent + 16'd1;
        end else begin
          r_word     <= w_word_next;
          r_byte_idx <= r_byte_idx + 1'b1;
        end
      end
    end
  end

  // Debug view: controller state, or the byte engine's state while sending.
  always_comb begin
    dbg_state = IDLE;
    case (r_state)
      DR_IDLE:  dbg_state = IDLE;
      DR_FETCH: dbg_state = FETCH;
      DR_LOAD:  dbg_state = LOAD;
      DR_SEND:  dbg_state = w_tx_state;
      default:  dbg_state = IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_tx_start),
    .i_data      (w_tx_data),
    .o_tx        (tx),
    .o_byte_done (w_byte_done),
    .o_state     (w_tx_state)
  );

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Testbench for fifo_uart_drain (DATA_WIDTH=16, CLKS_PER_BIT=4).
// Honours UART_DRAIN_PARITY_EN for 8E1 frames.
module tb_fifo_uart_drain;
  import uart_drain_pkg::*;

  localparam int DW    = 16;
  localparam int CPB   = 4;
  localparam int BYTES = 2;
`ifdef UART_DRAIN_PARITY_EN
  localparam int FBITS = 11;
  localparam int WDUR  = 88;
`else
  localparam int FBITS = 10;
  localparam int WDUR  = 80;
`endif
  localparam int LOGN  = 16384;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic [15:0]   words_sent;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  fifo_uart_drain #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .tx           (tx),
    .busy         (busy),
    .words_sent   (words_sent),
    .dbg_state    (dbg_state)
  );

  // ---------------- FIFO model (registered read data) ----------------
  logic [DW-1:0] fifo_q[$];
  int            fifo_cnt = 0;
  int            pop_while_empty = 0;
  assign fifo_empty = (fifo_cnt == 0);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_cnt == 0) pop_while_empty++;
      else begin
        fifo_rd_data <= fifo_q.pop_front();
        fifo_cnt--;
      end
    end
  end

  // ---------------- monitor: per-cycle log sampled on negedge ----------------
  int          cyc = 0;
  logic        tx_log[LOGN];
  logic        busy_log[LOGN];
  logic [15:0] ws_log[LOGN];
  int          pulse_cyc[$];

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      tx_log[cyc]   = tx;
      busy_log[cyc] = busy;
      ws_log[cyc]   = words_sent;
    end
    if (fifo_rd_en === 1'b1) pulse_cyc.push_back(cyc);
    cyc++;
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [15:0]   exp_ws = '0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: line level 'off' cycles after the start bit of word w begins.
  function automatic logic model_tx(input logic [DW-1:0] w, input int off);
    int fl;
    int k;
    int pos;
    logic [7:0] b;
    fl  = FBITS * CPB;
    k   = off / fl;
    pos = (off % fl) / CPB;
    b   = 8'(w >> (8 * (BYTES - 1 - k)));
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (FBITS == 11 && pos == 9) return ^b;
    return 1'b1;
  endfunction

  // Mid-bit sample of frame bit 'pos' of byte k of the word popped at cycle p.
  function automatic int sample_bit(input int p, input int k, input int pos);
    int c;
    c = p + 2 + k * FBITS * CPB + pos * CPB + CPB / 2;
    if (c >= LOGN) return -1;
    return int'(tx_log[c]);
  endfunction

  function automatic int decode_byte(input int p, input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = sample_bit(p, k, j + 1) == 1;
    return int'(b);
  endfunction

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_cnt++;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int budget, output int ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output int ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1; break; end
    end
  endtask

  task automatic wait_drain(input int budget, output int ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (fifo_cnt == 0 && busy === 1'b0) begin ok = 1; break; end
    end
  endtask

  // Full check of one transmitted word whose pop pulse was at cycle p.
  task automatic check_word(input int p);
    logic [DW-1:0] w;
    int mism;
    int bmis;
    int c;
    if (exp_q.size() == 0) begin chk("exp_q_underflow", 0, 1); return; end
    w = exp_q.pop_front();
    if (p + WDUR + 4 >= LOGN) begin chk("log_range", p, 0); return; end
    mism = 0;
    if (tx_log[p+1] !== 1'b1) mism++;
    for (int o = 0; o < WDUR; o++) if (tx_log[p+2+o] !== model_tx(w, o)) mism++;
    chk("tx_wave", mism, 0);
    bmis = 0;
    for (int k = p; k < p + 2 + WDUR; k++) if (busy_log[k] !== 1'b1) bmis++;
    if (busy_log[p+2+WDUR] !== 1'b0) bmis++;
    chk("busy_window", bmis, 0);
    c = p + 1;
    while (c < p + WDUR + 4 && busy_log[c] === 1'b1) c++;
    chk("word_cycles", c - (p + 2), WDUR);
    chk("ws_hold", int'(ws_log[p+1+WDUR]), int'(exp_ws));
    exp_ws = exp_ws + 16'd1;
    chk("ws_step", int'(ws_log[p+2+WDUR]), int'(exp_ws));
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [15:0] word;
    logic [7:0]  b_hi;
    logic [7:0]  b_lo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok;
    int n0;
    int p;
    int v_tx;
    int v_rd;
    int v_busy;
    int v_ws;
    int mism;
    int b2b[6];
    int f_a5[11];
    int f_5a[11];

    vecs[0] = '{16'hA55A, 8'hA5, 8'h5A};
    vecs[1] = '{16'h0001, 8'h00, 8'h01};
    vecs[2] = '{16'h8000, 8'h80, 8'h00};
    vecs[3] = '{16'hFFFF, 8'hFF, 8'hFF};
    vecs[4] = '{16'h1234, 8'h12, 8'h34};
    vecs[5] = '{16'hA507, 8'hA5, 8'h07};
    b2b  = '{8'h00, 8'h01, 8'h80, 8'h00, 8'hFF, 8'hFF};
    f_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    f_5a = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1};

    // --- reset held with a non-empty FIFO and enable high ---
    rst_n  = 1'b0;
    enable = 1'b1;
    push_word(16'h00FF);
    v_tx = 0; v_rd = 0; v_busy = 0; v_ws = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) v_tx++;
      if (fifo_rd_en !== 1'b0) v_rd++;
      if (busy !== 1'b0) v_busy++;
      if (words_sent !== 16'd0) v_ws++;
    end
    chk("rst_tx", v_tx, 0);
    chk("rst_rd_en", v_rd, 0);
    chk("rst_busy", v_busy, 0);
    chk("rst_words_sent", v_ws, 0);
    chk("rst_no_pop", fifo_cnt, 1);
    chk("rst_state", int'(dbg_state), int'(IDLE));

    // --- enable low: nothing starts ---
    enable = 1'b0;
    rst_n  = 1'b1;
    n0 = pulse_cyc.size();
    v_tx = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) v_tx++;
    end
    chk("en0_pulses", pulse_cyc.size() - n0, 0);
    chk("en0_tx_idle", v_tx, 0);
    chk("en0_fifo_kept", fifo_cnt, 1);

    // --- reset during the DATA state of byte 0 ---
    enable = 1'b1;
    wait_pulse(10, ok);
    chk("mid_rst_pulse", ok, 1);
    wait_cycles(8);
    chk("mid_rst_in_data", int'(dbg_state), int'(DATA));
    chk("mid_rst_tx_low", int'(tx), 0);
    push_word(16'h1357);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", int'(tx), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ws", int'(words_sent), 0);
    void'(exp_q.pop_front());
    wait_cycles(3);
    n0 = pulse_cyc.size();
    rst_n = 1'b1;
    wait_drain(WDUR + 40, ok);
    chk("mid_rst_recover", ok, 1);
    enable = 1'b0;
    wait_cycles(4);
    chk("mid_rst_pulses", pulse_cyc.size() - n0, 1);
    if (pulse_cyc.size() > n0) check_word(pulse_cyc[n0]);

    // --- table-driven single words ---
    for (int i = 0; i < 6; i++) begin
      n0 = pulse_cyc.size();
      push_word(vecs[i].word);
      enable = 1'b1;
      wait_drain(WDUR + 40, ok);
      chk("vec_drain", ok, 1);
      enable = 1'b0;
      wait_cycles(4);
      chk("vec_pulses", pulse_cyc.size() - n0, 1);
      if (pulse_cyc.size() > n0) begin
        p = pulse_cyc[n0];
        chk("vec_byte_hi", decode_byte(p, 0), int'(vecs[i].b_hi));
        chk("vec_byte_lo", decode_byte(p, 1), int'(vecs[i].b_lo));
        check_word(p);
        chk("vec_ws", int'(words_sent), int'(exp_ws));
        if (i == 0) begin
          mism = 0;
          for (int j = 0; j < FBITS; j++) begin
`ifdef UART_DRAIN_PARITY_EN
            if (j == 9) continue;
`endif
            if (sample_bit(p, 0, j) != f_a5[(FBITS == 11 && j == 10) ? 9 : j]) mism++;
            if (sample_bit(p, 1, j) != f_5a[(FBITS == 11 && j == 10) ? 9 : j]) mism++;
          end
          chk("frame_a5_5a", mism, 0);
        end
`ifdef UART_DRAIN_PARITY_EN
        if (i == 5) begin
          chk("parity_a5", sample_bit(p, 0, 9), 0);
          chk("parity_07", sample_bit(p, 1, 9), 1);
        end
`endif
      end
    end

    // --- back-to-back: three queued words ---
    push_word(16'h0001);
    push_word(16'h8000);
    push_word(16'hFFFF);
    n0 = pulse_cyc.size();
    enable = 1'b1;
    wait_drain(3 * (WDUR + 3) + 40, ok);
    chk("b2b_drain", ok, 1);
    enable = 1'b0;
    wait_cycles(4);
    chk("b2b_pulses", pulse_cyc.size() - n0, 3);
    if (pulse_cyc.size() >= n0 + 3) begin
      chk("b2b_gap1", pulse_cyc[n0+1] - pulse_cyc[n0], 3 + WDUR);
      chk("b2b_gap2", pulse_cyc[n0+2] - pulse_cyc[n0+1], 3 + WDUR);
      mism = 0;
      for (int j = 0; j < 6; j++)
        if (decode_byte(pulse_cyc[n0 + j/2], j % 2) != b2b[j]) mism++;
      chk("b2b_bytes", mism, 0);
      for (int j = 0; j < 3; j++) check_word(pulse_cyc[n0+j]);
    end
    chk("b2b_ws", int'(words_sent), int'(exp_ws));

    // --- enable dropped 10 cycles into a word ---
    push_word(16'h3C3C);
    push_word(16'hC3C3);
    n0 = pulse_cyc.size();
    enable = 1'b1;
    wait_pulse(10, ok);
    chk("endrop_pulse", ok, 1);
    wait_cycles(10);
    enable = 1'b0;
    wait_idle(WDUR + 20, ok);
    chk("endrop_done", ok, 1);
    wait_cycles(20);
    chk("endrop_pulses", pulse_cyc.size() - n0, 1);
    chk("endrop_fifo_left", fifo_cnt, 1);
    if (pulse_cyc.size() > n0) check_word(pulse_cyc[n0]);

    // --- randomized words pushed at random times ---
    n0 = pulse_cyc.size();
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      wait_cycles($urandom_range(0, 120));
      push_word(DW'($urandom));
    end
    wait_drain(13 * (WDUR + 3) + 200, ok);
    chk("rand_drain", ok, 1);
    enable = 1'b0;
    wait_cycles(4);
    chk("rand_pulses", pulse_cyc.size() - n0, 13);
    mism = 0;
    for (int j = n0 + 1; j < pulse_cyc.size(); j++)
      if (pulse_cyc[j] - pulse_cyc[j-1] < 3 + WDUR) mism++;
    chk("rand_spacing", mism, 0);
    for (int j = n0; j < pulse_cyc.size(); j++) check_word(pulse_cyc[j]);

    // --- final bookkeeping ---
    chk("pop_while_empty", pop_while_empty, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("final_ws", int'(words_sent), int'(exp_ws));
    chk("final_tx_idle", int'(tx), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
